i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C responder (target) for the existing i2c_master bus, used on-chip for loopback and bench testing and for exposing control registers to an external host.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs.
- Takes a register pointer byte, then performs auto-incrementing register writes and reads through a simple strobe interface.

Parameters:
- ADDR, 7'h58, 7-bit slave address to respond to.
- PTR_W, 8, register pointer width; pointer wraps modulo 2^PTR_W.

Ports:
- clk  input  1  system clock; SCL/SDA each held high/low ≥4 clk cycles.
- reset  input  1  asynchronous, active-low reset.
- i2c_scl  input  1  bus clock; open-drain line, externally pulled up.
- i2c_sda  inout  1  bus data; block drives only 1'b0 or 1'bz.
- wr_strobe  output  1  one-cycle pulse: write wr_data to wr_addr.
- wr_addr  output  PTR_W  register address for write.
- wr_data  output  8  register write data.
- rd_addr  output  PTR_W  current pointer, for combinational/registered read.
- rd_data  input  8  register read data; sampled 1 clk after rd_strobe.
- rd_strobe  output  1  one-cycle pulse when a read byte is loaded; pointer increments after.
- busy  output  1  high from a matched address until STOP or a repeated START.

Behaviour:
- Reset (reset=0), async: all outputs 0, sda released (z), pointer=0, state IDLE.
- Input sync: 2-flop synchronisers on SCL and SDA; edge detect on the synced values.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high.
- START/STOP are detected in every state and override the current state.
- START, including a repeated START: go to ADDR, bit count = 0, sda released.
- STOP: go to IDLE, sda released, busy=0. The pointer is retained.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
- Bit sampling and ACK protocol:
  - Data bits are sampled on the SCL rising edge, MSB first. SDA is changed only after the SCL falling edge.
- ADDR: shift in 8 bits (7 address bits, then R/W).
  - Address == ADDR: drive sda=0 from the 8th SCL falling edge to the 9th SCL falling edge (ACK); busy=1.
  - R/W=0: ACK goes to PTR. R/W=1: ACK goes to READ.
  - Mismatch: no ACK, go to IDLE, ignore everything until the next START.
- PTR: 8 bits load the pointer; ACK; then WRITE.
- WRITE: on the 8th bit, wr_strobe=1 for one clk with wr_addr=pointer and wr_data=byte.
  - The byte is ACKed; pointer+1 at the ACK. Repeat until STOP or START.
- READ: on entry and after each master ACK, rd_strobe pulses and rd_data is latched next clk into the shift register.
  - MSB is driven before the first SCL rise. Drive sda=0 for 0-bits; release for 1-bits.
  - Pointer+1 after each byte.
- READ_ACK: release sda and sample the 9th bit.
  - 0 (ACK): load the next byte.
  - 1 (NACK): go to IDLE-wait (sda released, busy stays 1 until STOP/START).
- Write-to-read sequence: a write of only the pointer then repeated START + read reads from the new pointer.
- Pointer wraps from 2^PTR_W-1 to 0.
- SDA changing while SCL high outside START/STOP is impossible by construction; it is treated as START/STOP per the rules above.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: after the synchronisers, each line passes a 3-sample majority filter.
  - A level change is accepted only after 3 consecutive equal samples.
  - Adds 2 clk of input latency; requires ≥6 clk per SCL phase.
  - Single-clk pulses on SCL/SDA are ignored.
- Undefined: synchronised signals are used directly; single-clk glitches are acted on.

Test Plan:
- Write: START, 0xB0 (0x58,W), 0x30, 0x01, STOP -> three ACKs seen; wr_strobe once with wr_addr=0x30, wr_data=0x01; busy 0 after STOP.
- Address mismatch: START, 0xA0, 0x30, STOP -> SDA never driven low by slave, no strobes, busy stays 0.
- Auto-increment and wrap: PTR_W=8, write ptr 0xFF, data 0x11, 0x22 -> strobes (0xFF,0x11) then (0x00,0x22).
- Read after repeated START: write ptr 0x10, Sr, 0xB1, then read 2 bytes with rd_data=addr^0x5A, master ACK then NACK -> bytes 0x4A, 0x4B on SDA; rd_strobe twice; SDA released after NACK.
- Reset mid-transfer: assert reset during the 4th data bit of a read -> sda z immediately, all outputs 0; next START+0xB0 is ACKed normally.
- With I2C_SLAVE_GLITCH_FILTER_EN: inject 1-clk low pulse on SDA while SCL high during a write byte -> no false START/STOP, byte received intact. Without the macro: a false START is detected.

Source files
------------

// File: rtl/i2c_slave.sv
// i2c_slave -- I2C target with a 7-bit address, a register pointer byte and
// auto-incrementing register writes/reads over a strobe interface.
//
// SCL/SDA are oversampled on clk. START/STOP override any state. After an
// address match (R/W=0) the first byte loads the pointer and the following
// bytes become wr_strobe pulses. With R/W=1, bytes are fetched through
// rd_strobe/rd_data and shifted out MSB first. The pointer increments after
// every byte and wraps modulo 2^PTR_W. The pointer is kept across STOP.
//
// Optional feature macro: I2C_SLAVE_GLITCH_FILTER_EN
//   Defined  : each synchronised line passes a 3-sample filter. A new level is
//              accepted only after 3 equal samples, so 1-clk pulses are dropped.
//              This adds 2 clk of latency, so each SCL phase needs >= 6 clk.
//   Undefined: the synchronised lines are used directly.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   i2c_scl    bus clock (open drain, pulled up externally)
//   i2c_sda    bus data; this block drives only 1'b0 or 1'bz
//   wr_strobe  one-cycle write pulse; wr_addr/wr_data are valid with it
//   rd_addr    current pointer, used to look up rd_data
//   rd_data    read data, captured 1 clk after rd_strobe
//   rd_strobe  one-cycle pulse requesting the next read byte
//   busy       high from an address match until STOP or START
module i2c_slave #(
    parameter logic [6:0] ADDR  = 7'h58,
    parameter int         PTR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i2c_scl,
    inout  wire              i2c_sda,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             rd_strobe,
    output logic             busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK
    } state_t;

    // ---------------- input conditioning ----------------
    // The synchronisers reset to 1, which is the idle bus level. This avoids
    // spurious edges when reset is released.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f;
    logic       scl_d, sda_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i2c_scl};
            sda_sync <= {sda_sync[0], i2c_sda};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_flt_q, sda_flt_q;

    // Take the new level as soon as the current sample and the two before it
    // agree. Otherwise hold the last accepted level.
    assign scl_f = (scl_sync[1] == scl_hist[0] && scl_sync[1] == scl_hist[1]) ? scl_sync[1] : scl_flt_q;
    assign sda_f = (sda_sync[1] == sda_hist[0] && sda_sync[1] == sda_hist[1]) ? sda_sync[1] : sda_flt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_hist  <= 2'b11;
            sda_hist  <= 2'b11;
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
        end else begin
            scl_hist  <= {scl_hist[0], scl_sync[1]};
            sda_hist  <= {sda_hist[0], sda_sync[1]};
            scl_flt_q <= scl_f;
            sda_flt_q <= sda_f;
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_f & ~scl_d;
    assign scl_fall  = ~scl_f &  scl_d;
    // SCL must be high on both samples, so an SDA change that lands on an
    // SCL edge is never taken for START/STOP.
    assign start_det = scl_f & scl_d &  sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d &  sda_f;

    // ---------------- protocol FSM ----------------
    state_t           state, state_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shreg, shreg_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic             sda_oe, sda_oe_n;
    logic             busy_n, wr_strobe_n, rd_strobe_n;
    logic [PTR_W-1:0] wr_addr_n;
    logic [7:0]       wr_data_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_strobe <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            ptr       <= ptr_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            wr_strobe <= wr_strobe_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            rd_strobe <= rd_strobe_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        ptr_n       = ptr;
        sda_oe_n    = sda_oe;
        busy_n      = busy;
        wr_strobe_n = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        rd_strobe_n = 1'b0;

        // The cycle after rd_strobe: capture the byte and drive its MSB while
        // SCL is still low.
        if (rd_strobe) begin
            shreg_n  = rd_data;
            sda_oe_n = ~rd_data[7];
        end

        if (start_det) begin
            state_n   = S_ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (stop_det) begin
            state_n  = S_IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_PTR, S_WRITE: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shreg_n   = {shreg[6:0], sda_f};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        // 8th falling edge: the byte is complete. Start the ACK here.
                        if (state == S_ADDR) begin
                            if (shreg[7:1] == ADDR) begin
                                sda_oe_n = 1'b1;
                                busy_n   = 1'b1;
                                state_n  = S_ADDR_ACK;
                            end else begin
                                state_n  = S_IDLE;
                            end
                        end else if (state == S_PTR) begin
                            ptr_n    = PTR_W'(shreg);
                            sda_oe_n = 1'b1;
                            state_n  = S_PTR_ACK;
                        end else begin
                            wr_strobe_n = 1'b1;
                            wr_addr_n   = ptr;
                            wr_data_n   = shreg;
                            sda_oe_n    = 1'b1;
                            state_n     = S_WRITE_ACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        if (shreg[0]) begin
                            state_n     = S_READ;
                            rd_strobe_n = 1'b1;
                        end else begin
                            state_n = S_PTR;
                        end
                    end
                end
                S_PTR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = S_WRITE;
                    end
                end
                S_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        ptr_n     = ptr + PTR_W'(1);
                        state_n   = S_WRITE;
                    end
                end
                S_READ: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe_n = 1'b0;
                        ptr_n    = ptr + PTR_W'(1);
                        state_n  = S_READ_ACK;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        sda_oe_n = ~shreg[6];
                    end
                end
                S_READ_ACK: begin
                    // bit_cnt == 9 means the master ACKed on this SCL high phase.
                    if (scl_rise) begin
                        if (sda_f) state_n   = S_IDLE;  // NACK: busy held until STOP/START
                        else       bit_cnt_n = 4'd9;
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        bit_cnt_n   = '0;
                        state_n     = S_READ;
                        rd_strobe_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;
    assign rd_addr = ptr;

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;
    localparam int H = 10;  // clk cycles per SCL phase

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic       wr_strobe, rd_strobe, busy;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.ADDR(7'h58), .PTR_W(8)) dut (
        .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(sda),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_strobe(rd_strobe), .busy(busy)
    );

    // Register file seen by the slave, and a transaction-level model of it
    logic [7:0] regs [256];
    logic [7:0] mdl_mem [256];
    logic [7:0] mdl_ptr;
    assign rd_data = regs[rd_addr];

    logic [7:0] wq_a[$], wq_d[$];
    int         rd_cnt = 0;
    bit         slave_low = 0;
    int         checks = 0, errors = 0;

    always @(posedge clk) if (wr_strobe) regs[wr_addr] <= wr_data;

    always @(negedge clk) begin
        if (wr_strobe) begin wq_a.push_back(wr_addr); wq_d.push_back(wr_data); end
        if (rd_strobe) rd_cnt++;
        if (sda === 1'b0 && !m_low) slave_low = 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- bus master primitives ----------------
    task automatic w(int n); repeat (n) @(negedge clk); endtask

    task automatic do_start();  // START or repeated START; leaves SCL low
        if (scl == 1'b0) begin w(2); m_low = 0; w(H); scl = 1; w(H); end
        m_low = 1; w(H); scl = 0;
    endtask

    task automatic do_stop();
        w(2); m_low = 1; w(H); scl = 1; w(H); m_low = 0; w(H);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            w(2); m_low = ~b[i]; w(H-2); scl = 1;
            if (i == glitch_bit) begin
                w(H/2); m_low = 1; w(1); m_low = 0; w(H/2-1);
            end else w(H);
            scl = 0;
        end
        w(2); m_low = 0; w(H-2); scl = 1; w(H/2);
        ack = (sda === 1'b0);
        w(H/2); scl = 0;
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            w(H); scl = 1; w(H/2);
            b[i] = (sda !== 1'b0);
            w(H/2); scl = 0;
        end
        w(2); m_low = send_ack; w(H-2); scl = 1; w(H); scl = 0; w(2); m_low = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 0; w(3);
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe got %b exp 0", wr_strobe); end
        checks++; if (rd_strobe !== 1'b0) begin errors++; $display("FAIL reset_rd_strobe got %b exp 0", rd_strobe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if ({wr_addr, wr_data, rd_addr} !== 24'h0) begin errors++; $display("FAIL reset_buses got %h exp 0", {wr_addr, wr_data, rd_addr}); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b exp 1", sda); end
        reset = 1; w(5);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        wq_a.delete(); wq_d.delete();
        do_start(); write_byte(8'hB0, -1, a0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b exp 1", busy); end
        write_byte(8'h30, -1, a1); write_byte(8'h01, -1, a2); do_stop(); w(4);
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL write_acks got %b exp 111", {a0, a1, a2}); end
        checks++; if (wq_a.size() != 1) begin errors++; $display("FAIL write_nstrobe got %0d exp 1", wq_a.size()); end
        else begin
            checks++; if ({wq_a[0], wq_d[0]} !== 16'h3001) begin errors++; $display("FAIL write_strobe got %h exp 3001", {wq_a[0], wq_d[0]}); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got %b exp 0", busy); end
        mdl_mem[8'h30] = 8'h01; mdl_ptr = 8'h31;
    endtask

    task automatic test_mismatch();
        logic a0, a1;
        int   rc;
        wq_a.delete(); wq_d.delete(); slave_low = 0; rc = rd_cnt;
        do_start(); write_byte(8'hA0, -1, a0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mism_busy got %b exp 0", busy); end
        write_byte(8'h30, -1, a1); do_stop(); w(4);
        checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL mism_acks got %b exp 00", {a0, a1}); end
        checks++; if (slave_low !== 1'b0) begin errors++; $display("FAIL mism_sda_low got %b exp 0", slave_low); end
        checks++; if (wq_a.size() + rd_cnt - rc != 0) begin errors++; $display("FAIL mism_strobes got %0d exp 0", wq_a.size() + rd_cnt - rc); end
    endtask

    task automatic test_wrap();
        logic a;
        int   nack = 0;
        wq_a.delete(); wq_d.delete();
        do_start();
        write_byte(8'hB0, -1, a); nack += !a;
        write_byte(8'hFF, -1, a); nack += !a;
        write_byte(8'h11, -1, a); nack += !a;
        write_byte(8'h22, -1, a); nack += !a;
        do_stop(); w(4);
        checks++; if (nack != 0) begin errors++; $display("FAIL wrap_acks got %0d nacks exp 0", nack); end
        checks++; if (wq_a.size() != 2) begin errors++; $display("FAIL wrap_nstrobe got %0d exp 2", wq_a.size()); end
        else begin
            checks++; if ({wq_a[0], wq_d[0], wq_a[1], wq_d[1]} !== 32'hFF11_0022) begin
                errors++; $display("FAIL wrap_strobes got %h exp ff110022", {wq_a[0], wq_d[0], wq_a[1], wq_d[1]}); end
        end
        mdl_mem[8'hFF] = 8'h11; mdl_mem[8'h00] = 8'h22; mdl_ptr = 8'h01;
    endtask

    task automatic test_read_sr();
        logic       a0, a1, a2;
        logic [7:0] b0, b1;
        int         rc;
        do_start(); write_byte(8'hB0, -1, a0); write_byte(8'h10, -1, a1);
        do_start(); write_byte(8'hB1, -1, a2);
        rc = rd_cnt;
        read_byte(1'b1, b0); read_byte(1'b0, b1); w(4);
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL rd_acks got %b exp 111", {a0, a1, a2}); end
        checks++; if ({b0, b1} !== 16'h4A4B) begin errors++; $display("FAIL rd_bytes got %h exp 4a4b", {b0, b1}); end
        checks++; if (rd_cnt - rc != 2) begin errors++; $display("FAIL rd_nstrobe got %0d exp 2", rd_cnt - rc); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rd_sda_nack got %b exp 1", sda); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_nack got %b exp 1", busy); end
        do_stop(); w(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_stop got %b exp 0", busy); end
        mdl_ptr = 8'h12;
    endtask

    task automatic test_reset_mid();
        logic a;
        do_start(); write_byte(8'hB0, -1, a); write_byte(8'h10, -1, a);
        do_start(); write_byte(8'hB1, -1, a);
        for (int k = 0; k < 3; k++) begin w(H); scl = 1; w(H); scl = 0; end
        w(H); scl = 1; w(H/2);
        // 0x10 holds 0x4A; its 4th bit is 0, so the slave is pulling SDA low
        checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rstmid_sda_before got %b exp 0", sda); end
        reset = 0; #1;
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rstmid_sda got %b exp 1", sda); end
        checks++; if ({wr_strobe, rd_strobe, busy, wr_addr, wr_data, rd_addr} !== 27'h0) begin
            errors++; $display("FAIL rstmid_outputs got %h exp 0", {wr_strobe, rd_strobe, busy, wr_addr, wr_data, rd_addr}); end
        w(2); scl = 1; m_low = 0; w(5); reset = 1; w(5);
        do_start(); write_byte(8'hB0, -1, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rstmid_ack got %b exp 1", a); end
        do_stop(); w(4);
        mdl_ptr = 8'h00;
    endtask

    task automatic test_glitch();
        logic a0, a1, a2, filt, bsy;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        filt = 1'b1;
`else
        filt = 1'b0;
`endif
        wq_a.delete(); wq_d.delete();
        do_start(); write_byte(8'hB0, -1, a0); write_byte(8'h80, -1, a1);
        write_byte(8'hA5, 7, a2);
        bsy = busy;
        do_stop(); w(4);
        checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL glitch_hdr_acks got %b exp 11", {a0, a1}); end
        checks++; if (a2 !== filt) begin errors++; $display("FAIL glitch_data_ack got %b exp %b", a2, filt); end
        checks++; if (bsy !== filt) begin errors++; $display("FAIL glitch_busy got %b exp %b", bsy, filt); end
        checks++; if (wq_a.size() != int'(filt)) begin errors++; $display("FAIL glitch_nstrobe got %0d exp %0d", wq_a.size(), filt); end
        else if (filt) begin
            checks++; if ({wq_a[0], wq_d[0]} !== 16'h80A5) begin errors++; $display("FAIL glitch_strobe got %h exp 80a5", {wq_a[0], wq_d[0]}); end
        end
        if (filt) begin mdl_mem[8'h80] = 8'hA5; mdl_ptr = 8'h81; end
        else mdl_ptr = 8'h80;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] p, b;
            logic [7:0] d[4];
            logic       a;
            int         n, nack;
            p = 8'($urandom_range(0, 255)); n = $urandom_range(1, 4); nack = 0;
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            wq_a.delete(); wq_d.delete();
            do_start();
            write_byte(8'hB0, -1, a); nack += !a;
            write_byte(p, -1, a); nack += !a;
            for (int i = 0; i < n; i++) begin write_byte(d[i], -1, a); nack += !a; end
            do_stop(); w(4);
            checks++; if (nack != 0) begin errors++; $display("FAIL rand_wr_acks it %0d got %0d nacks exp 0", it, nack); end
            checks++; if (wq_a.size() != n) begin errors++; $display("FAIL rand_wr_n it %0d got %0d exp %0d", it, wq_a.size(), n); end
            else for (int i = 0; i < n; i++) begin
                checks++; if ({wq_a[i], wq_d[i]} !== {8'(p + 8'(i)), d[i]}) begin
                    errors++; $display("FAIL rand_wr it %0d got %h exp %h", it, {wq_a[i], wq_d[i]}, {8'(p + 8'(i)), d[i]}); end
            end
            for (int i = 0; i < n; i++) mdl_mem[8'(p + 8'(i))] = d[i];
            mdl_ptr = 8'(p + 8'(n));

            // Read back, either from a fresh pointer or the retained one
            wq_a.delete(); wq_d.delete(); nack = 0;
            if ($urandom_range(0, 1) == 1) begin
                p = 8'($urandom_range(0, 255));
                do_start(); write_byte(8'hB0, -1, a); nack += !a;
                write_byte(p, -1, a); nack += !a;
                mdl_ptr = p;
            end
            do_start(); write_byte(8'hB1, -1, a); nack += !a;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                read_byte(i < n - 1, b);
                checks++; if (b !== mdl_mem[8'(mdl_ptr + 8'(i))]) begin
                    errors++; $display("FAIL rand_rd it %0d byte %0d got %h exp %h", it, i, b, mdl_mem[8'(mdl_ptr + 8'(i))]); end
            end
            do_stop(); w(4);
            mdl_ptr = 8'(mdl_ptr + 8'(n));
            checks++; if (nack != 0 || wq_a.size() != 0) begin
                errors++; $display("FAIL rand_rd_hdr it %0d got nacks %0d strobes %0d exp 0 0", it, nack, wq_a.size()); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            regs[i]    = 8'(i) ^ 8'h5A;
            mdl_mem[i] = 8'(i) ^ 8'h5A;
        end
        mdl_ptr = 8'h00;
        test_reset();
        test_write();
        test_mismatch();
        test_wrap();
        test_read_sr();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
